// File: rtl/match_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : match_scoreboard_pkg
// Description : Shared constants, state enum and segment decoder for the
//               match scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package match_scoreboard_pkg;

    // Winner encodings
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_T1   = 2'b01;
    localparam logic [1:0] WIN_T2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Match state
    typedef enum logic [0:0] {
        ST_PLAYING = 1'b0,
        ST_FINAL   = 1'b1
    } state_t;

    // Seven-segment patterns, gfedcba, active-low
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_D     = 7'h21;

    // 5-bit digit codes: 0..9 are numeric, the rest are symbols
    localparam logic [4:0] CODE_BLANK = 5'd16;
    localparam logic [4:0] CODE_DASH  = 5'd17;
    localparam logic [4:0] CODE_D     = 5'd18;

    // Digit positions, 7 is leftmost
    localparam logic [2:0] DIG_T1_TENS  = 3'd7;
    localparam logic [2:0] DIG_T1_ONES  = 3'd6;
    localparam logic [2:0] DIG_MID      = 3'd5;
    localparam logic [2:0] DIG_MINUTES  = 3'd4;
    localparam logic [2:0] DIG_SEC_TENS = 3'd3;
    localparam logic [2:0] DIG_SEC_ONES = 3'd2;
    localparam logic [2:0] DIG_T2_TENS  = 3'd1;
    localparam logic [2:0] DIG_T2_ONES  = 3'd0;

    // Map a digit code to its active-low segment pattern
    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] s;
        s = SEG_BLANK;
        case (code)
            5'd0:      s = 7'h40;
            5'd1:      s = 7'h79;
            5'd2:      s = 7'h24;
            5'd3:      s = 7'h30;
            5'd4:      s = 7'h19;
            5'd5:      s = 7'h12;
            5'd6:      s = 7'h02;
            5'd7:      s = 7'h78;
            5'd8:      s = 7'h00;
            5'd9:      s = 7'h10;
            CODE_DASH: s = SEG_DASH;
            CODE_D:    s = SEG_D;
            default:   s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/match_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : match_scoreboard_if
// Description : Game-controller inputs and display/result outputs of the
//               match scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
interface match_scoreboard_if;
    logic       team1_score;
    logic       team2_score;
    logic [7:0] time_left;
    logic       game_over;
    logic [6:0] team1_goals;
    logic [6:0] team2_goals;
    logic [1:0] winner;
    logic [6:0] seg;
    logic [7:0] an;

    // Game controller / test side
    modport master (
        output team1_score, team2_score, time_left, game_over,
        input  team1_goals, team2_goals, winner, seg, an
    );

    // Scoreboard side
    modport slave (
        input  team1_score, team2_score, time_left, game_over,
        output team1_goals, team2_goals, winner, seg, an
    );
endinterface
`default_nettype wire

// File: rtl/match_scoreboard_seven_seg_mux.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_mux
// Description : 8-digit multiplexed seven-segment driver. Steps the active
//               digit from 7 down to 0 every REFRESH_DIV cycles and registers
//               the segment pattern together with the digit enable.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_mux
    import match_scoreboard_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0][4:0] i_digits,
    output logic [6:0]      o_seg,
    output logic [7:0]      o_an
);

    localparam int            CW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] c_term = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [6:0]    r_seg;
    logic [7:0]    r_an;

    // Refresh counter, digit index and the seg/an pair registered together
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_idx <= 3'd7;
            r_seg <= SEG_BLANK;
            r_an  <= 8'hFF;
        end else begin
            if (r_cnt == c_term) begin
                r_cnt <= '0;
                r_idx <= r_idx - 3'd1;  // 0 wraps back to 7
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_seg <= seg_decode(i_digits[r_idx]);
            r_an  <= ~(8'd1 << r_idx);
        end
    end

    assign o_seg = r_seg;
    assign o_an  = r_an;

endmodule
`default_nettype wire

// File: rtl/match_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : match_scoreboard
// Description : Counts goals per team from score edges, converts time_left to
//               m:ss, latches the final result at game over and drives an
//               8-digit multiplexed seven-segment display.
// Revision    : 1.0 - initial release
// ============================================================================
module match_scoreboard
    import match_scoreboard_pkg::*;
#(
    parameter int MAX_GOALS   = 99,
    parameter int REFRESH_DIV = 50000
) (
    input  logic               clk,
    input  logic               reset,
    match_scoreboard_if.slave  bus
);

    localparam logic [6:0] c_max = 7'(MAX_GOALS);

    // Index 0 is team 1, index 1 is team 2
    logic [1:0] w_score;
    logic [1:0] w_edge;
    logic [1:0] r_prev;
    logic [6:0] r_bin  [2];
    logic [3:0] r_tens [2];
    logic [3:0] r_ones [2];

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_count_en;
    logic       w_latch_win;
    logic [1:0] w_win_calc;
    logic [1:0] r_winner;

    logic [2:0] w_min;
    logic [5:0] w_sec;
    logic [3:0] w_sec_tens;
    logic [3:0] w_sec_ones;
    logic [2:0] r_min;
    logic [3:0] r_sec_tens;
    logic [3:0] r_sec_ones;

    logic [4:0] w_mid;
    logic [7:0][4:0] w_digits;

    assign w_score = {bus.team2_score, bus.team1_score};
    assign w_edge  = w_score & ~r_prev;

    // Edge registers and saturating binary/BCD goal counters in lockstep
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 2'b00;
            for (int t = 0; t < 2; t++) begin
                r_bin[t]  <= 7'd0;
                r_tens[t] <= 4'd0;
                r_ones[t] <= 4'd0;
            end
        end else begin
            r_prev <= w_score;
            for (int t = 0; t < 2; t++) begin
                if (w_count_en && w_edge[t] && (r_bin[t] < c_max)) begin
                    r_bin[t] <= r_bin[t] + 7'd1;
                    if (r_ones[t] == 4'd9) begin
                        r_ones[t] <= 4'd0;
                        r_tens[t] <= r_tens[t] + 4'd1;
                    end else begin
                        r_ones[t] <= r_ones[t] + 4'd1;
                    end
                end
            end
        end
    end

    // Match state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_PLAYING;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state; a goal arriving with game_over is not counted
    always_comb begin
        w_state_nxt = r_state;
        w_count_en  = 1'b0;
        w_latch_win = 1'b0;
        case (r_state)
            ST_PLAYING: begin
                if (bus.game_over) begin
                    w_state_nxt = ST_FINAL;
                    w_latch_win = 1'b1;
                end else begin
                    w_count_en = 1'b1;
                end
            end
            ST_FINAL: begin
                w_state_nxt = ST_FINAL;
            end
            default: begin
                w_state_nxt = ST_PLAYING;
            end
        endcase
    end

    // Result from the counts as they stand before any same-cycle goal
    always_comb begin
        w_win_calc = WIN_DRAW;
        if (r_bin[0] > r_bin[1]) begin
            w_win_calc = WIN_T1;
        end else if (r_bin[1] > r_bin[0]) begin
            w_win_calc = WIN_T2;
        end
    end

    // Winner is frozen on entry to FINAL
    always_ff @(posedge clk) begin
        if (reset) begin
            r_winner <= WIN_NONE;
        end else if (w_latch_win) begin
            r_winner <= w_win_calc;
        end
    end

    // Minutes by compare/subtract against 240/180/120/60
    always_comb begin
        w_min = 3'd0;
        w_sec = 6'd0;
        if (bus.time_left >= 8'd240) begin
            w_min = 3'd4;
            w_sec = 6'(bus.time_left - 8'd240);
        end else if (bus.time_left >= 8'd180) begin
            w_min = 3'd3;
            w_sec = 6'(bus.time_left - 8'd180);
        end else if (bus.time_left >= 8'd120) begin
            w_min = 3'd2;
            w_sec = 6'(bus.time_left - 8'd120);
        end else if (bus.time_left >= 8'd60) begin
            w_min = 3'd1;
            w_sec = 6'(bus.time_left - 8'd60);
        end else begin
            w_sec = bus.time_left[5:0];
        end
    end

    // Seconds tens/ones by compare/subtract against 50..10
    always_comb begin
        w_sec_tens = 4'd0;
        w_sec_ones = 4'd0;
        if (w_sec >= 6'd50) begin
            w_sec_tens = 4'd5;
            w_sec_ones = 4'(w_sec - 6'd50);
        end else if (w_sec >= 6'd40) begin
            w_sec_tens = 4'd4;
            w_sec_ones = 4'(w_sec - 6'd40);
        end else if (w_sec >= 6'd30) begin
            w_sec_tens = 4'd3;
            w_sec_ones = 4'(w_sec - 6'd30);
        end else if (w_sec >= 6'd20) begin
            w_sec_tens = 4'd2;
            w_sec_ones = 4'(w_sec - 6'd20);
        end else if (w_sec >= 6'd10) begin
            w_sec_tens = 4'd1;
            w_sec_ones = 4'(w_sec - 6'd10);
        end else begin
            w_sec_ones = w_sec[3:0];
        end
    end

    // Registered time digits
    always_ff @(posedge clk) begin
        if (reset) begin
            r_min      <= 3'd0;
            r_sec_tens <= 4'd0;
            r_sec_ones <= 4'd0;
        end else begin
            r_min      <= w_min;
            r_sec_tens <= w_sec_tens;
            r_sec_ones <= w_sec_ones;
        end
    end

    // Middle digit: dash while playing, result symbol once final
    always_comb begin
        w_mid = CODE_DASH;
        if (r_state == ST_FINAL) begin
            case (r_winner)
                WIN_T1:   w_mid = 5'd1;
                WIN_T2:   w_mid = 5'd2;
                WIN_DRAW: w_mid = CODE_D;
                default:  w_mid = CODE_DASH;
            endcase
        end
    end

    // Digit map with leading-zero blanking on the goal tens digits
    always_comb begin
        w_digits               = '0;
        w_digits[DIG_T1_TENS]  = (r_tens[0] == 4'd0) ? CODE_BLANK : {1'b0, r_tens[0]};
        w_digits[DIG_T1_ONES]  = {1'b0, r_ones[0]};
        w_digits[DIG_MID]      = w_mid;
        w_digits[DIG_MINUTES]  = {2'b00, r_min};
        w_digits[DIG_SEC_TENS] = {1'b0, r_sec_tens};
        w_digits[DIG_SEC_ONES] = {1'b0, r_sec_ones};
        w_digits[DIG_T2_TENS]  = (r_tens[1] == 4'd0) ? CODE_BLANK : {1'b0, r_tens[1]};
        w_digits[DIG_T2_ONES]  = {1'b0, r_ones[1]};
    end

    seven_seg_mux #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_mux (
        .clk      (clk),
        .reset    (reset),
        .i_digits (w_digits),
        .o_seg    (bus.seg),
        .o_an     (bus.an)
    );

    assign bus.team1_goals = r_bin[0];
    assign bus.team2_goals = r_bin[1];
    assign bus.winner      = r_winner;

endmodule
`default_nettype wire
